// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - fetch read port responder with a direct-mapped line buffer
// Hits answer combinationally; misses stall fetch and fill one entry in two 32-bit bus beats.
module instr_fetch_responder #(
  parameter int          ENTRIES   = 2,
  parameter int          MEM_AW    = 32,
  parameter logic [63:0] INSTR_NOP = 64'h0000_0000_0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_read_in,
  input  logic [63:0]       instr_address_in,
  input  logic              flush_in,
  output logic [63:0]       instr_read_value_out,
  output logic              stall_out,
  output logic              mem_req_out,
  output logic [MEM_AW-1:0] mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [31:0]       mem_rdata_in
);

  localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int LINE_W = 61;

  typedef enum logic [1:0] {IDLE, REQ_LO, REQ_HI} state_t;

  state_t              state_q, state_d;
  logic [LINE_W-1:0]   fill_line_q, fill_line_d;
  logic [31:0]         lo_word_q, lo_word_d;
  logic                discard_q, discard_d;
  logic                mem_req_q, mem_req_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [LINE_W-1:0]   tag_q  [ENTRIES];
  logic [LINE_W-1:0]   tag_d  [ENTRIES];
  logic [63:0]         data_q [ENTRIES];
  logic [63:0]         data_d [ENTRIES];

  logic [LINE_W-1:0]   req_line;
  logic [IDX_W-1:0]    req_idx;
  logic [IDX_W-1:0]    fill_idx;
  logic                hit;

  function automatic logic [IDX_W-1:0] line_idx(input logic [LINE_W-1:0] line);
    if (ENTRIES > 1) return line[IDX_W-1:0];
    else             return '0;
  endfunction

  // The whole line address is kept as the tag; the index bits inside it always match.
  assign req_line = instr_address_in[63:3];
  assign req_idx  = line_idx(req_line);
  assign fill_idx = line_idx(fill_line_q);
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_line);

  assign stall_out            = (state_q != IDLE) || (instr_read_in && !hit);
  assign instr_read_value_out = (instr_read_in && hit) ? data_q[req_idx] : INSTR_NOP;
  assign mem_req_out          = mem_req_q;
  assign mem_addr_out         = mem_addr_q;

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    lo_word_d   = lo_word_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;

    case (state_q)
      IDLE: begin
        if (instr_read_in && !hit && !flush_in) begin
          state_d     = REQ_LO;
          fill_line_d = req_line;
          mem_req_d   = 1'b1;
          mem_addr_d  = {req_line[MEM_AW-4:0], 3'b000};
        end
      end
      REQ_LO: begin
        if (flush_in) discard_d = 1'b1;
        if (mem_ack_in) begin
          lo_word_d  = mem_rdata_in;
          state_d    = REQ_HI;
          mem_addr_d = {fill_line_q[MEM_AW-4:0], 3'b100};
        end
      end
      REQ_HI: begin
        if (mem_ack_in) begin
          data_d[fill_idx]  = {mem_rdata_in, lo_word_q};
          tag_d[fill_idx]   = fill_line_q;
          valid_d[fill_idx] = !(discard_q || flush_in);
          state_d           = IDLE;
          mem_req_d         = 1'b0;
          mem_addr_d        = '0;
          discard_d         = 1'b0;
        end else if (flush_in) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over any fill write landing on the same edge.
    if (flush_in) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fill_line_q <= '0;
      lo_word_q   <= '0;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      valid_q     <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      lo_word_q   <= lo_word_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      valid_q     <= valid_d;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
